// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register-to-register bus move sequencer with round-robin arbitration
//
// Optional feature macro: BUS_XFER_TURNAROUND_EN (adds a dead TURN cycle after DONE).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high reset
//   req      - per-requester level request, held until done
//   req_src  - flattened source register indices, slice r for requester r
//   req_dst  - flattened destination register indices, slice r for requester r
//   grant    - one-hot, requester currently being served
//   done     - one-cycle completion pulse to the served requester
//   err      - one-cycle pulse with done when the request was rejected
//   busy     - high whenever the sequencer is not idle
//   reg_cs   - per-register chip select
//   reg_we   - per-register write enable (register captures the bus)
//   reg_oe   - per-register output enable (register drives the bus)

module bus_xfer_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int NUM_REQ  = 2,
  parameter int IDX_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_src,
  input  logic [NUM_REQ*IDX_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic [NUM_REGS-1:0]      reg_cs,
  output logic [NUM_REGS-1:0]      reg_we,
  output logic [NUM_REGS-1:0]      reg_oe
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0]  REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

`ifdef BUS_XFER_TURNAROUND_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_REJ  = 3'd2,
    ST_DONE = 3'd3,
    ST_TURN = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_REJ  = 3'd2,
    ST_DONE = 3'd3
  } state_t;
`endif

  state_t state, state_n;

  logic [PTR_W-1:0]    ptr, ptr_n;
  logic [PTR_W-1:0]    gidx, gidx_n;
  logic [NUM_REQ-1:0]  grant_n, done_n;
  logic                err_n, busy_n;
  logic [NUM_REGS-1:0] cs_n, we_n, oe_n;

  // Round-robin search: first set req bit at or above ptr, wrapping.
  logic             arb_hit;
  logic [PTR_W-1:0] arb_idx;
  int               cand;

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = PTR_W'(cand);
      end
    end
  end

  logic [IDX_W-1:0] sel_src, sel_dst;
  logic             sel_valid;

  always_comb begin
    sel_src   = req_src[int'(arb_idx)*IDX_W +: IDX_W];
    sel_dst   = req_dst[int'(arb_idx)*IDX_W +: IDX_W];
    sel_valid = (sel_src != sel_dst) &&
                (int'(sel_src) < NUM_REGS) &&
                (int'(sel_dst) < NUM_REGS);
  end

  // Next-state and next-output logic. Every output is a register, so the
  // strobes for the XFER cycle are computed here while still in IDLE; that
  // latch of the strobe pattern is what captures the src/dst indices.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    grant_n = grant;
    done_n  = '0;
    err_n   = 1'b0;
    cs_n    = '0;
    we_n    = '0;
    oe_n    = '0;

    case (state)
      ST_IDLE: begin
        if (arb_hit) begin
          gidx_n  = arb_idx;
          grant_n = REQ_ONE << arb_idx;
          if (sel_valid) begin
            state_n = ST_XFER;
            cs_n    = (REG_ONE << sel_src) | (REG_ONE << sel_dst);
            oe_n    = REG_ONE << sel_src;
            we_n    = REG_ONE << sel_dst;
          end else begin
            state_n = ST_REJ;
          end
        end
      end

      ST_XFER: begin
        state_n = ST_DONE;
        done_n  = grant;
      end

      ST_REJ: begin
        state_n = ST_DONE;
        done_n  = grant;
        err_n   = 1'b1;
      end

      ST_DONE: begin
        grant_n = '0;
        if (gidx == PTR_W'(NUM_REQ - 1)) begin
          ptr_n = '0;
        end else begin
          ptr_n = gidx + PTR_W'(1);
        end
`ifdef BUS_XFER_TURNAROUND_EN
        state_n = ST_TURN;
`else
        state_n = ST_IDLE;
`endif
      end

`ifdef BUS_XFER_TURNAROUND_EN
      // Dead cycle so the previous driver has fully released the bus.
      ST_TURN: begin
        state_n = ST_IDLE;
      end
`endif

      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gidx   <= '0;
      grant  <= '0;
      done   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      reg_cs <= '0;
      reg_we <= '0;
      reg_oe <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gidx   <= gidx_n;
      grant  <= grant_n;
      done   <= done_n;
      err    <= err_n;
      busy   <= busy_n;
      reg_cs <= cs_n;
      reg_we <= we_n;
      reg_oe <= oe_n;
    end
  end

endmodule
